// File: rtl/eqv_miter_pkg.sv
// Shared types and the per-lane compare used by the stream miter.
package eqv_miter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ErrNone      = 2'd0,
    ErrMismatch  = 2'd1,
    ErrUnderflow = 2'd2,
    ErrOverflow  = 2'd3
  } err_e;

  // Lanes narrower than this are zero-extended by the caller; zeros always compare equal.
  localparam int unsigned LaneMaxW = 64;

  function automatic logic lane_mismatch(input logic [LaneMaxW-1:0] gold,
                                         input logic [LaneMaxW-1:0] gate,
                                         input logic [LaneMaxW-1:0] xmask);
    return |(~xmask & (gold ^ gate));
  endfunction

endpackage

// File: rtl/eqv_gold_fifo.sv
// Gold-sample FIFO with empty-FIFO bypass; full/empty via an extra pointer wrap bit.
module eqv_gold_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DW    = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DW-1:0]          wdata,
  output logic [DW-1:0]          rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = (AW + 1)'(1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic          wr_en, rd_en, bypass;

  assign level  = wr_ptr_q - rd_ptr_q;
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // Push and pop on an empty FIFO hand the incoming word straight to the reader.
  assign bypass = push & pop & empty;
  assign wr_en  = push & ~bypass & (~full | pop);
  assign rd_en  = pop & ~empty;
  assign rdata  = bypass ? wdata : mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (rd_en) rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

endmodule

// File: rtl/eqv_stream_miter.sv
// Sequential miter: buffers gold samples, compares each against the next gate sample
// with gold don't-care masking, and latches the first error.
module eqv_stream_miter
  import eqv_miter_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      gold_valid,
  input  logic [CHANNELS*WIDTH-1:0] gold_data,
  input  logic [CHANNELS*WIDTH-1:0] gold_xmask,
  input  logic                      gate_valid,
  input  logic [CHANNELS*WIDTH-1:0] gate_data,
  output logic [1:0]                state_o,
  output logic                      pass,
  output logic                      fail,
  output logic [1:0]                err_code,
  output logic [CHANNELS-1:0]       fail_chan,
  output logic [CNT_W-1:0]          fail_index,
  output logic [CNT_W-1:0]          cmp_count,
  output logic [$clog2(DEPTH):0]    fifo_level
);
  localparam int unsigned DW = CHANNELS * WIDTH;
  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0]    LvlOne = LW'(1);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e               state_q, state_d;
  err_e                 err_q, err_d;
  logic                 fail_q;
  logic [CHANNELS-1:0]  fail_chan_q, chan_d;
  logic [CNT_W-1:0]     fail_index_q, cmp_count_q;
  logic                 clear, push, pop, cmp_en, underflow, overflow;
  logic                 fifo_full, fifo_empty;
  logic [2*DW-1:0]      head;
  logic [DW-1:0]        head_data, head_mask;
  logic [CHANNELS-1:0]  lane_mis;

  assign clear = start & ((state_q == StIdle) | (state_q == StDone));
  assign push  = gold_valid & (state_q == StRun);
  assign pop   = gate_valid & ((state_q == StRun) | (state_q == StDrain));

  eqv_gold_fifo #(
    .DEPTH (DEPTH),
    .DW    (2 * DW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .wdata ({gold_xmask, gold_data}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign head_data = head[DW-1:0];
  assign head_mask = head[2*DW-1:DW];
  assign cmp_en    = pop & (~fifo_empty | push);
  assign underflow = pop & fifo_empty & ~push;
  assign overflow  = push & fifo_full & ~pop;

  always_comb begin
    lane_mis = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      lane_mis[c] = lane_mismatch(LaneMaxW'(head_data[c*WIDTH +: WIDTH]),
                                  LaneMaxW'(gate_data[c*WIDTH +: WIDTH]),
                                  LaneMaxW'(head_mask[c*WIDTH +: WIDTH]));
    end
  end

  always_comb begin
    err_d  = ErrNone;
    chan_d = '0;
    if (cmp_en && |lane_mis) begin
      err_d  = ErrMismatch;
      chan_d = lane_mis;
    end else if (underflow) begin
      err_d = ErrUnderflow;
    end else if (overflow) begin
      err_d = ErrOverflow;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q        <= ErrNone;
      fail_q       <= 1'b0;
      fail_chan_q  <= '0;
      fail_index_q <= '0;
      cmp_count_q  <= '0;
    end else if (clear) begin
      err_q        <= ErrNone;
      fail_q       <= 1'b0;
      fail_chan_q  <= '0;
      fail_index_q <= '0;
      cmp_count_q  <= '0;
    end else begin
      if (cmp_en && cmp_count_q != CntMax) cmp_count_q <= cmp_count_q + CntOne;
      // Only the first error is recorded; fail_index is the pre-increment count.
      if (!fail_q && err_d != ErrNone) begin
        fail_q       <= 1'b1;
        err_q        <= err_d;
        fail_chan_q  <= chan_d;
        fail_index_q <= cmp_count_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start) state_d = StRun;
      StRun: begin
        if (fail_q)    state_d = StDone;
        else if (stop) state_d = StDrain;
      end
      StDrain: begin
        if (fail_q || fifo_empty || (fifo_level == LvlOne && pop)) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  assign state_o    = state_q;
  assign pass       = (state_q == StDone) & ~fail_q;
  assign fail       = fail_q;
  assign err_code   = err_q;
  assign fail_chan  = fail_chan_q;
  assign fail_index = fail_index_q;
  assign cmp_count  = cmp_count_q;

endmodule

// File: doc/eqv_stream_miter.md
Name: eqv_stream_miter

Overview:
- Sequential equivalence miter for equivalence-check partitions. Compares a gold output stream against a gate output stream across CHANNELS lanes of WIDTH bits.
- Tolerates variable gate latency by buffering gold samples in a FIFO.
- Honours gold don't-care bits, the X-as-wildcard rule of the combinational compare.
- Sits between gold/gate partition instances in simulation and formal benches. Reports sticky pass/fail, the failing lanes and the failing compare index.

Parameters:
- WIDTH, 8, bits per channel
- CHANNELS, 4, number of compared lanes
- DEPTH, 8, gold FIFO entries; power of two, minimum 2
- CNT_W, 16, compare counter width

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  pulse: clear and begin a run
- stop  input  1  pulse: end of stimulus, begin drain
- gold_valid  input  1  gold sample present
- gold_data  input  CHANNELS*WIDTH  gold sample
- gold_xmask  input  CHANNELS*WIDTH  1 = gold bit is don't-care
- gate_valid  input  1  gate sample present
- gate_data  input  CHANNELS*WIDTH  gate sample
- state_o  output  2  current FSM state
- pass  output  1  run completed clean
- fail  output  1  sticky failure
- err_code  output  2  00 none, 01 mismatch, 10 underflow, 11 overflow
- fail_chan  output  CHANNELS  lanes mismatching at first failure
- fail_index  output  CNT_W  cmp_count value at first failure
- cmp_count  output  CNT_W  completed compares, saturating
- fifo_level  output  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset: state IDLE, FIFO empty, all outputs 0.
- FSM states: IDLE, RUN, DRAIN, DONE. Fail is a sticky flag valid in RUN/DRAIN and forces DONE.
- IDLE/DONE + start -> RUN. Clears the FIFO, counters, fail, err_code, fail_chan and fail_index.
- RUN + start: ignored.
- RUN + stop -> DRAIN. Pushes are ignored in DRAIN.
- DRAIN with FIFO empty (after any same-cycle pop) -> DONE.
- Failure detected -> DONE next cycle with fail=1. pass=1 only in DONE with fail=0.
- start and stop in the same cycle: start wins in IDLE/DONE; stop wins in RUN.
- Push: gold_valid in RUN writes {data, xmask}.
- Pop: gate_valid in RUN/DRAIN reads the head.
- Simultaneous push and pop on an empty FIFO: bypass. The incoming gold sample is compared directly and occupancy is unchanged.
- Push on a full FIFO without a same-cycle pop -> overflow error. Sample dropped.
- Pop on an empty FIFO without a same-cycle push -> underflow error. No compare performed.
- Compare rule, per bit: ok = xmask | (gold == gate). A lane mismatches if any bit is not ok.
- Compare is registered. Results (cmp_count increment, fail, fail_chan) appear 1 cycle after the pop.
- The first error latches err_code, fail_chan and fail_index. Later errors do not overwrite them.
- Same-cycle priority: mismatch over underflow over overflow.
- cmp_count saturates at 2^CNT_W-1 and never wraps.
- FIFO pointers wrap modulo DEPTH, with an extra bit to distinguish full from empty.
- Async reset mid-run: immediate return to the reset state. No partial results are retained.

Decomposition:
- Package eqv_miter_pkg holds:
  - state enum {IDLE, RUN, DRAIN, DONE}
  - err_code enum {ERR_NONE, ERR_MISMATCH, ERR_UNDERFLOW, ERR_OVERFLOW}
  - a lane-compare function taking gold, gate and xmask for one WIDTH slice
- Sub-module eqv_gold_fifo: parametrised synchronous FIFO, DEPTH x 2*CHANNELS*WIDTH. Exposes full/empty/level, supports the bypass case, async active-high reset.

Test Plan:
- Reset, start, then 5 gold samples with gate delayed 3 cycles, identical data, then stop -> DONE, pass=1, cmp_count=5, peak fifo_level=3.
- Gold lane 2 = 0xA5 with xmask 0x0F, gate lane 2 = 0xAA -> no mismatch. Gate 0x55 on the same sample -> fail=1, err_code=01, fail_chan=4'b0100.
- Mismatch injected on compare index 6 of 10 -> fail_index=6. A second mismatch at index 8 leaves fail_index=6 and fail_chan unchanged.
- gate_valid with FIFO empty and no push -> err_code=10 one cycle later. Same cycle with gold_valid and equal data -> bypass compare, no error, fifo_level stays 0.
- DEPTH=8: push 9 samples with no pops -> err_code=11, fifo_level=8, DONE next cycle.
- Assert rst mid-DRAIN with 4 entries queued -> all outputs 0 and state IDLE immediately. A subsequent start produces a clean run.
